spi_memory: RTL and testbench

SPI_MEMORY -- requirements
Module: spi_memory

---
 rtl/spi_memory_pkg.sv | 15 +
 rtl/spi_memory_sync_edge.sv | 44 ++++
 rtl/spi_memory.sv | 158 +++++++++++++++
 tb/tb_spi_memory.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_memory_pkg.sv
// Shared widths and FSM encoding for the SPI memory bridge.
package spi_memory_pkg;

  localparam int SPI_MEM_ADDR_WIDTH = 15;
  localparam int SPI_MEM_DATA_WIDTH = 8;
  localparam int BYTE_WIDTH         = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADDR_HI = 2'd1,
    ST_ADDR_LO = 2'd2,
    ST_DATA    = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_memory_sync_edge.sv
// Brings the asynchronous SPI pins into the clk domain and turns sck and the
// chip select into single-cycle edge pulses. mosi gets the same two-flop
// latency as sck so a detected sck rise lines up with the bit it clocks.
module spi_sync_edge
  import spi_memory_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic select_n_i,
  input  logic sck_i,
  input  logic mosi_i,
  output logic mosi_o,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic sel_fall_o,
  output logic sel_rise_o
);

  // Select history clears to 0 so that a chip select already low at reset
  // release is not seen as a fresh falling edge.
  logic [2:0] sel_q;
  logic [2:0] sck_q;
  logic [1:0] mosi_q;

  // Two synchronizer stages plus one history stage for edge detection.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sel_q  <= '0;
      sck_q  <= '0;
      mosi_q <= '0;
    end else begin
      sel_q  <= {sel_q[1:0], select_n_i};
      sck_q  <= {sck_q[1:0], sck_i};
      mosi_q <= {mosi_q[0], mosi_i};
    end
  end

  assign mosi_o     = mosi_q[1];
  assign sck_rise_o = sck_q[1] & ~sck_q[2];
  assign sck_fall_o = ~sck_q[1] & sck_q[2];
  assign sel_fall_o = ~sel_q[1] & sel_q[2];
  assign sel_rise_o = sel_q[1] & ~sel_q[2];

endmodule

// File: rtl/spi_memory.sv
// SPI (mode 0) slave bridging a serial command stream onto a parallel memory
// port. Byte 1 carries the write flag and high address bits, byte 2 the low
// address byte, and every following byte is a data word with auto-increment.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_IDLE    | chip select inactive (or not yet re-armed after reset)
//   ST_ADDR_HI | shifting byte 1: write flag + upper address bits
//   ST_ADDR_LO | shifting byte 2: lower address byte
//   ST_DATA    | streaming data words, address increments per word
module spi_memory
  import spi_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = SPI_MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SPI_MEM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  _select,
  input  logic                  sck,
  input  logic                  mosi,
  output logic                  miso,
  output logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd,
  output logic                  wr
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam int HI_W  = ADDR_WIDTH - DATA_WIDTH;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic mosi_s;
  logic sck_rise;
  logic sck_fall;
  logic sel_fall;
  logic sel_rise;

  spi_sync_edge u_sync (
    .clk_i      (clk),
    .reset_i    (reset),
    .select_n_i (_select),
    .sck_i      (sck),
    .mosi_i     (mosi),
    .mosi_o     (mosi_s),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall),
    .sel_fall_o (sel_fall),
    .sel_rise_o (sel_rise)
  );

  spi_state_e            state_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [DATA_WIDTH-2:0] shift_in_q;
  logic [DATA_WIDTH-1:0] shift_out_q;
  logic [HI_W-1:0]       addr_hi_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  rd_q;
  logic                  wr_q;
  logic                  write_q;
  logic                  inc_pending_q;

  logic [DATA_WIDTH-1:0] byte_d;
  logic [ADDR_WIDTH-1:0] addr_inc_d;
  logic                  byte_done_d;

  // The byte completed by the current sck rise includes the bit being sampled.
  assign byte_d      = {shift_in_q, mosi_s};
  assign addr_inc_d  = addr_q + ADDR_WIDTH'(1);
  assign byte_done_d = (bit_cnt_q == LAST_BIT);

  // Command decode, data streaming and strobe generation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      shift_in_q    <= '0;
      shift_out_q   <= '0;
      addr_hi_q     <= '0;
      addr_q        <= '0;
      data_out_q    <= '0;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      write_q       <= 1'b0;
      inc_pending_q <= 1'b0;
    end else begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;

      // A write holds the address for its strobe cycle, then steps on.
      if (inc_pending_q) begin
        addr_q        <= addr_inc_d;
        inc_pending_q <= 1'b0;
      end

      // data_in is only valid while rd is high, so capture it then.
      if (rd_q) begin
        shift_out_q <= data_in;
      end

      if (sel_rise) begin
        state_q    <= ST_IDLE;
        bit_cnt_q  <= '0;
        shift_in_q <= '0;
      end else if (sel_fall) begin
        state_q     <= ST_ADDR_HI;
        bit_cnt_q   <= '0;
        shift_in_q  <= '0;
        shift_out_q <= '0;
        write_q     <= 1'b0;
      end else if (state_q != ST_IDLE) begin
        if (sck_rise) begin
          shift_in_q <= byte_d[DATA_WIDTH-2:0];
          bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
          if (byte_done_d) begin
            case (state_q)
              ST_ADDR_HI: begin
                write_q   <= byte_d[DATA_WIDTH-1];
                addr_hi_q <= byte_d[HI_W-1:0];
                state_q   <= ST_ADDR_LO;
              end
              ST_ADDR_LO: begin
                addr_q  <= {addr_hi_q, byte_d};
                state_q <= ST_DATA;
                rd_q    <= ~write_q;
              end
              ST_DATA: begin
                if (write_q) begin
                  data_out_q    <= byte_d;
                  wr_q          <= 1'b1;
                  inc_pending_q <= 1'b1;
                end else begin
                  addr_q <= addr_inc_d;
                  rd_q   <= 1'b1;
                end
              end
              default: state_q <= ST_IDLE;
            endcase
          end
        end else if (sck_fall && (state_q == ST_DATA) && (bit_cnt_q != '0)) begin
          // The fall trailing a byte boundary must not shift: the freshly
          // fetched MSB has to stay on miso for the first rise of the next byte.
          shift_out_q <= {shift_out_q[DATA_WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  assign miso     = (state_q == ST_IDLE) ? 1'bz :
                    (state_q == ST_DATA) ? shift_out_q[DATA_WIDTH-1] : 1'b0;
  assign addr     = addr_q;
  assign data_out = data_out_q;
  assign rd       = rd_q;
  assign wr       = wr_q;

endmodule

// File: tb/tb_spi_memory.sv
// Directed bench for spi_memory: SPI mode 0 master driven from one initial
// block, strobes logged on the falling clk edge, memory returns addr[7:0].
module tb_spi_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic        _select;
  logic        sck;
  logic        mosi;
  wire         miso;
  logic [14:0] addr;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        rd;
  logic        wr;

  int n_asserts = 0;
  int n_fails   = 0;

  logic [14:0] wr_addr_log [64];
  logic [7:0]  wr_data_log [64];
  logic [14:0] rd_addr_log [64];
  int          wr_cnt      = 0;
  int          rd_cnt      = 0;
  int          overlap_cnt = 0;
  logic [7:0]  rx [6];

  always #5 clk = ~clk;

  assign data_in = addr[7:0];

  spi_memory dut (
    .clk      (clk),
    .reset    (reset),
    ._select  (_select),
    .sck      (sck),
    .mosi     (mosi),
    .miso     (miso),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .rd       (rd),
    .wr       (wr)
  );

  always @(negedge clk) begin
    if (rd && wr) overlap_cnt++;
    if (wr) begin
      if (wr_cnt < 64) begin
        wr_addr_log[wr_cnt] = addr;
        wr_data_log[wr_cnt] = data_out;
      end
      wr_cnt++;
    end
    if (rd) begin
      if (rd_cnt < 64) rd_addr_log[rd_cnt] = addr;
      rd_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rxb);
    rxb = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      repeat (6) @(negedge clk);
      rxb[i] = miso;
      sck = 1'b1;
      repeat (6) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic spi_xfer(input logic [7:0] tx [6], input int n);
    _select = 1'b0;
    for (int k = 0; k < n; k++) spi_bits(tx[k], 8, rx[k]);
    repeat (6) @(negedge clk);
    _select = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Expected writes: n consecutive addresses from start (15-bit wrap).
  task automatic check_writes(input string tag, input int base, input logic [14:0] start,
                              input logic [7:0] d [4]);
    logic [14:0] ea;
    for (int i = 0; i < 4; i++) begin
      ea = start + 15'(i);
      check($sformatf("%s_wr_addr%0d", tag, i), 32'(wr_addr_log[base + i]), 32'(ea));
      check($sformatf("%s_wr_data%0d", tag, i), 32'(wr_data_log[base + i]), 32'(d[i]));
    end
  endtask

  task automatic check_reads(input string tag, input int base, input logic [14:0] start);
    logic [14:0] ea;
    for (int i = 0; i < 5; i++) begin
      ea = start + 15'(i);
      check($sformatf("%s_rd_addr%0d", tag, i), 32'(rd_addr_log[base + i]), 32'(ea));
    end
  endtask

  initial begin
    logic [7:0] v [6];
    logic [7:0] d [4];
    logic [7:0] junk;
    int wb;
    int rb;

    reset   = 1'b1;
    _select = 1'b1;
    sck     = 1'b0;
    mosi    = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_addr", 32'(addr), 32'h0);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_rd", 32'(rd), 32'h0);
    check("rst_wr", 32'(wr), 32'h0);
    reset = 1'b0;
    repeat (8) @(negedge clk);

    // Write DE AD 01 02 04 08
    wb = wr_cnt; rb = rd_cnt;
    v = '{8'hDE, 8'hAD, 8'h01, 8'h02, 8'h04, 8'h08};
    spi_xfer(v, 6);
    check("t1_miso_addr_hi", 32'(rx[0]), 32'h00);
    check("t1_miso_addr_lo", 32'(rx[1]), 32'h00);
    check("t1_wr_count", 32'(wr_cnt - wb), 32'd4);
    check("t1_rd_count", 32'(rd_cnt - rb), 32'd0);
    d = '{8'h01, 8'h02, 8'h04, 8'h08};
    check_writes("t1", wb, 15'h5EAD, d);
    check("t1_final_addr", 32'(addr), 32'h5EB1);

    // Write BE EF 11 22 44 88
    wb = wr_cnt; rb = rd_cnt;
    v = '{8'hBE, 8'hEF, 8'h11, 8'h22, 8'h44, 8'h88};
    spi_xfer(v, 6);
    check("t2_wr_count", 32'(wr_cnt - wb), 32'd4);
    check("t2_rd_count", 32'(rd_cnt - rb), 32'd0);
    d = '{8'h11, 8'h22, 8'h44, 8'h88};
    check_writes("t2", wb, 15'h3EEF, d);

    // Read 5A FE + four dummies
    wb = wr_cnt; rb = rd_cnt;
    v = '{8'h5A, 8'hFE, 8'hA5, 8'h3C, 8'hFF, 8'h00};
    spi_xfer(v, 6);
    check("t3_miso_addr_hi", 32'(rx[0]), 32'h00);
    check("t3_miso_addr_lo", 32'(rx[1]), 32'h00);
    check("t3_miso0", 32'(rx[2]), 32'hFE);
    check("t3_miso1", 32'(rx[3]), 32'hFF);
    check("t3_miso2", 32'(rx[4]), 32'h00);
    check("t3_miso3", 32'(rx[5]), 32'h01);
    check("t3_rd_count", 32'(rd_cnt - rb), 32'd5);
    check("t3_wr_count", 32'(wr_cnt - wb), 32'd0);
    check_reads("t3", rb, 15'h5AFE);
    check("t3_data_out_kept", 32'(data_out), 32'h88);

    // Read 7F FE across the address wrap
    wb = wr_cnt; rb = rd_cnt;
    v = '{8'h7F, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00};
    spi_xfer(v, 6);
    check("t4_miso0", 32'(rx[2]), 32'hFE);
    check("t4_miso1", 32'(rx[3]), 32'hFF);
    check("t4_miso2", 32'(rx[4]), 32'h00);
    check("t4_miso3", 32'(rx[5]), 32'h01);
    check("t4_rd_count", 32'(rd_cnt - rb), 32'd5);
    check("t4_wr_count", 32'(wr_cnt - wb), 32'd0);
    check_reads("t4", rb, 15'h7FFE);

    // Write FF FE across the address wrap
    wb = wr_cnt; rb = rd_cnt;
    v = '{8'hFF, 8'hFE, 8'h11, 8'h22, 8'h44, 8'h88};
    spi_xfer(v, 6);
    check("t5_wr_count", 32'(wr_cnt - wb), 32'd4);
    check("t5_rd_count", 32'(rd_cnt - rb), 32'd0);
    d = '{8'h11, 8'h22, 8'h44, 8'h88};
    check_writes("t5", wb, 15'h7FFE, d);
    check("t5_final_addr", 32'(addr), 32'h0002);

    // Chip select raised after 4 bits of a data byte
    wb = wr_cnt; rb = rd_cnt;
    _select = 1'b0;
    spi_bits(8'hDE, 8, junk);
    spi_bits(8'hAD, 8, junk);
    spi_bits(8'h5C, 4, junk);
    repeat (6) @(negedge clk);
    _select = 1'b1;
    repeat (8) @(negedge clk);
    check("t6_abort_wr", 32'(wr_cnt - wb), 32'd0);
    check("t6_abort_rd", 32'(rd_cnt - rb), 32'd0);
    wb = wr_cnt;
    v = '{8'h92, 8'h34, 8'hAB, 8'h00, 8'h00, 8'h00};
    spi_xfer(v, 3);
    check("t6_next_wr_count", 32'(wr_cnt - wb), 32'd1);
    check("t6_next_wr_addr", 32'(wr_addr_log[wb]), 32'h1234);
    check("t6_next_wr_data", 32'(wr_data_log[wb]), 32'hAB);

    // Reset mid-byte with chip select held low
    wb = wr_cnt; rb = rd_cnt;
    _select = 1'b0;
    spi_bits(8'hDE, 8, junk);
    spi_bits(8'hAD, 8, junk);
    spi_bits(8'h5C, 4, junk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("t7_rst_addr", 32'(addr), 32'h0);
    check("t7_rst_data_out", 32'(data_out), 32'h0);
    spi_bits(8'hFF, 4, junk);
    spi_bits(8'hBE, 8, junk);
    spi_bits(8'hEF, 8, junk);
    spi_bits(8'h11, 8, junk);
    repeat (6) @(negedge clk);
    check("t7_no_wr_after_reset", 32'(wr_cnt - wb), 32'd0);
    check("t7_no_rd_after_reset", 32'(rd_cnt - rb), 32'd0);
    _select = 1'b1;
    repeat (8) @(negedge clk);
    wb = wr_cnt;
    v = '{8'h9A, 8'hBC, 8'h55, 8'h00, 8'h00, 8'h00};
    spi_xfer(v, 3);
    check("t7_next_wr_count", 32'(wr_cnt - wb), 32'd1);
    check("t7_next_wr_addr", 32'(wr_addr_log[wb]), 32'h1ABC);
    check("t7_next_wr_data", 32'(wr_data_log[wb]), 32'h55);
    check("t7_final_addr", 32'(addr), 32'h1ABD);

    check("rd_wr_overlap", 32'(overlap_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
